// File: rtl/cache.sv
// Direct-mapped read-only-allocate data cache: 1-cycle registered lookup, full-line
// install from the memory side, and word updates that only touch resident lines.
module cache #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic                  i_we,
  input  logic [31:0]           i_data,
  input  logic                  i_bwe,
  input  logic [LINE_WIDTH-1:0] i_bdata,
  output logic [LINE_WIDTH-1:0] o_data,
  output logic                  o_hit,
  output logic [1:0]            o_bindex
);

  localparam int NLINES    = 1 << INDEX_WIDTH;
  localparam int TAG_LSB   = 4 + INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - TAG_LSB;

  logic [NLINES-1:0]     valid_q;
  logic [TAG_WIDTH-1:0]  tag_mem  [NLINES];
  logic [LINE_WIDTH-1:0] data_mem [NLINES];

  logic [LINE_WIDTH-1:0] data_q, data_d;
  logic                  hit_q, hit_d;
  logic [1:0]            bindex_q, bindex_d;

  logic [INDEX_WIDTH-1:0] r_idx, w_idx;
  logic [TAG_WIDTH-1:0]   r_tag, w_tag;
  logic [1:0]             w_word;
  logic                   w_hit, do_install, do_word;
  logic [LINE_WIDTH-1:0]  rd_line;
  logic [TAG_WIDTH-1:0]   rd_tag;
  logic                   rd_valid;

  // Byte-offset bits are never used: all accesses are whole words or lines.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_raddr[1:0], i_waddr[1:0]};

  always_comb begin
    r_idx      = i_raddr[TAG_LSB-1:4];
    r_tag      = i_raddr[ADDR_WIDTH-1:TAG_LSB];
    w_idx      = i_waddr[TAG_LSB-1:4];
    w_tag      = i_waddr[ADDR_WIDTH-1:TAG_LSB];
    w_word     = i_waddr[3:2];
    w_hit      = valid_q[w_idx] && (tag_mem[w_idx] == w_tag);
    do_install = i_bwe;
    do_word    = i_we && !i_bwe && w_hit;

    rd_line  = data_mem[r_idx];
    rd_tag   = tag_mem[r_idx];
    rd_valid = valid_q[r_idx];
    // Write-first forwarding so a same-index lookup sees the post-write line.
    if (do_install && (w_idx == r_idx)) begin
      rd_line  = i_bdata;
      rd_tag   = w_tag;
      rd_valid = 1'b1;
    end else if (do_word && (w_idx == r_idx)) begin
      rd_line[32*w_word +: 32] = i_data;
    end

    hit_d    = rd_valid && (rd_tag == r_tag);
    data_d   = rd_line;
    bindex_d = i_raddr[3:2];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q  <= '0;
      hit_q    <= 1'b0;
      data_q   <= '0;
      bindex_q <= 2'd0;
    end else begin
      if (do_install) valid_q[w_idx] <= 1'b1;
      hit_q    <= hit_d;
      data_q   <= data_d;
      bindex_q <= bindex_d;
    end
  end

  // Arrays are not reset; gating on i_rst_n drops any write coinciding with reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (do_install) begin
        tag_mem[w_idx]  <= w_tag;
        data_mem[w_idx] <= i_bdata;
      end else if (do_word) begin
        data_mem[w_idx][32*w_word +: 32] <= i_data;
      end
    end
  end

  assign o_data   = data_q;
  assign o_hit    = hit_q;
  assign o_bindex = bindex_q;

endmodule

// File: tb/tb_cache.sv
// Directed bench for cache: install, word-write hit/miss, conflict eviction,
// same-edge forwarding, install-over-write priority and asynchronous reset.
module tb_cache;

  logic         clk;
  logic         rst_n;
  logic [31:0]  raddr;
  logic [31:0]  waddr;
  logic         we;
  logic [31:0]  wdata;
  logic         bwe;
  logic [127:0] bdata;
  logic [127:0] o_data;
  logic         o_hit;
  logic [1:0]   o_bindex;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] L2 = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
  localparam logic [127:0] L3 = 128'h33330003_33330002_33330001_33330000;
  localparam logic [127:0] L4 = 128'h55550003_55550002_55550001_55550000;

  cache dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_raddr  (raddr),
    .i_waddr  (waddr),
    .i_we     (we),
    .i_data   (wdata),
    .i_bwe    (bwe),
    .i_bdata  (bdata),
    .o_data   (o_data),
    .o_hit    (o_hit),
    .o_bindex (o_bindex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total_cnt++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      pass_cnt++;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] a);
    raddr = a;
    step();
  endtask

  task automatic install(input logic [31:0] a, input logic [127:0] d);
    bwe = 1'b1; waddr = a; bdata = d;
    step();
    bwe = 1'b0;
  endtask

  task automatic word_write(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  logic [127:0] exp_line;

  initial begin
    rst_n = 1'b0; raddr = '0; waddr = '0; we = 1'b0; wdata = '0; bwe = 1'b0; bdata = '0;
    #23;
    check("reset_hit", {127'd0, o_hit}, 128'd0);
    check("reset_data", o_data, 128'd0);
    check("reset_bindex", {126'd0, o_bindex}, 128'd0);
    rst_n = 1'b1;
    step();

    lookup(32'h0000_0100);
    check("cold_miss_hit", {127'd0, o_hit}, 128'd0);
    check("cold_miss_bindex", {126'd0, o_bindex}, 128'd0);

    raddr = 32'h0;
    install(32'h100, L1);
    lookup(32'h108);
    check("install_hit", {127'd0, o_hit}, 128'd1);
    check("install_bindex", {126'd0, o_bindex}, 128'd2);
    check("install_data", o_data, L1);

    word_write(32'h104, 32'hDEADBEEF);
    lookup(32'h100);
    exp_line = 128'h44444444_33333333_DEADBEEF_11111111;
    check("wr_hit_hit", {127'd0, o_hit}, 128'd1);
    check("wr_hit_data", o_data, exp_line);
    check("wr_hit_bindex", {126'd0, o_bindex}, 128'd0);

    word_write(32'h2004, 32'h12345678);
    lookup(32'h2000);
    check("wr_miss_noalloc", {127'd0, o_hit}, 128'd0);

    // Same index, other tag: must not modify the resident line.
    word_write(32'h1104, 32'h0BADF00D);
    lookup(32'h100);
    check("wr_tagmiss_hit", {127'd0, o_hit}, 128'd1);
    check("wr_tagmiss_data", o_data, exp_line);

    install(32'h1100, L2);
    lookup(32'h100);
    check("conflict_old_miss", {127'd0, o_hit}, 128'd0);
    lookup(32'h1100);
    check("conflict_new_hit", {127'd0, o_hit}, 128'd1);
    check("conflict_new_data", o_data, L2);

    raddr = 32'h30C;
    install(32'h300, L3);
    check("fwd_install_hit", {127'd0, o_hit}, 128'd1);
    check("fwd_install_bindex", {126'd0, o_bindex}, 128'd3);
    check("fwd_install_data", o_data, L3);

    raddr = 32'h300;
    word_write(32'h308, 32'hFEEDC0DE);
    check("fwd_word_data", o_data, 128'h33330003_FEEDC0DE_33330001_33330000);

    bwe = 1'b1; we = 1'b1; waddr = 32'h300; bdata = L4; wdata = 32'hCAFEF00D;
    step();
    bwe = 1'b0; we = 1'b0;
    lookup(32'h300);
    check("bwe_wins_hit", {127'd0, o_hit}, 128'd1);
    check("bwe_wins_data", o_data, L4);

    raddr = 32'h300;
    install(32'h400, L1);
    check("indep_idx_data", o_data, L4);
    lookup(32'h400);
    check("indep_idx_hit", {127'd0, o_hit}, 128'd1);

    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_hit", {127'd0, o_hit}, 128'd0);
    check("async_rst_data", o_data, 128'd0);
    step();
    rst_n = 1'b1;
    lookup(32'h300);
    check("post_rst_300", {127'd0, o_hit}, 128'd0);
    lookup(32'h1100);
    check("post_rst_1100", {127'd0, o_hit}, 128'd0);
    lookup(32'h400);
    check("post_rst_400", {127'd0, o_hit}, 128'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
